// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Handshake and line signals between a word producer and the UART transmitter.
//
// Parameter:
//   UART_DATA_LENGTH - data bits per frame (must match the transmitter)
//
// Signals:
//   data_i        word to send, sampled by the transmitter only on accept
//   data_valid_i  producer request to send data_i
//   ready_o       transmitter idle and able to accept a word
//   tx_o          serial line, idles high
//   done_strb_o   one-cycle pulse in the last cycle of a frame's stop bit
//
// Modports:
//   master - the word producer (drives data_i / data_valid_i)
//   slave  - the transmitter (drives ready_o / tx_o / done_strb_o)
// -----------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int unsigned UART_DATA_LENGTH = 8
);
    logic [UART_DATA_LENGTH-1:0] data_i;
    logic                        data_valid_i;
    logic                        ready_o;
    logic                        tx_o;
    logic                        done_strb_o;

    modport master (
        output data_i,
        output data_valid_i,
        input  ready_o,
        input  tx_o,
        input  done_strb_o
    );

    modport slave (
        input  data_i,
        input  data_valid_i,
        output ready_o,
        output tx_o,
        output done_strb_o
    );
endinterface

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: serialises one word per frame as start bit (0), data bits
// LSB first, optional even-parity bit, one stop bit (1). Each bit lasts
// BAUD_COUNTS_PER_BIT clock cycles. All outputs are registered.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   - a parity bit (XOR of the accepted word) follows the data bits
//   undefined - plain 8N1-style framing, no parity state or logic
//
// Parameters:
//   UART_DATA_LENGTH           data bits per frame
//   BAUD_COUNTS_PER_BIT        clock cycles per bit
//   BAUD_RATE_COUNTER_BITWIDTH baud counter width, holds BAUD_COUNTS_PER_BIT-1
//   TX_COUNTER_BITWIDTH        bit counter width, holds UART_DATA_LENGTH-1
//
// Ports:
//   clk_i     clock, rising edge
//   reset_ni  asynchronous active-low reset; aborts any frame in flight
//   bus       uart_tx_if slave modport (data_i, data_valid_i, ready_o,
//             tx_o, done_strb_o)
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned UART_DATA_LENGTH           = 8,
    parameter int unsigned BAUD_COUNTS_PER_BIT        = 521,
    parameter int unsigned BAUD_RATE_COUNTER_BITWIDTH = 10,
    parameter int unsigned TX_COUNTER_BITWIDTH        = 3
) (
    input  logic     clk_i,
    input  logic     reset_ni,
    uart_tx_if.slave bus
);

    typedef enum logic [2:0] {
        stIDLE,
        stSTARTBIT,
        stSENDING,
`ifdef UART_TX_PARITY_EN
        stPARITY,
`endif
        stSTOPBIT
    } state_t;

    localparam logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] BAUD_LAST =
        BAUD_RATE_COUNTER_BITWIDTH'(BAUD_COUNTS_PER_BIT - 1);

    // Count value one cycle before the end of a bit; only meaningful when a
    // bit lasts at least two cycles.
    localparam logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] BAUD_PRE_LAST =
        BAUD_RATE_COUNTER_BITWIDTH'((BAUD_COUNTS_PER_BIT > 1) ? BAUD_COUNTS_PER_BIT - 2 : 0);

    localparam logic [TX_COUNTER_BITWIDTH-1:0] BIT_LAST =
        TX_COUNTER_BITWIDTH'(UART_DATA_LENGTH - 1);

    // With one-cycle bits the stop bit's only cycle is also its last, so the
    // done strobe must be raised on entry to the stop bit.
    localparam logic DONE_ON_ENTRY = (BAUD_COUNTS_PER_BIT == 1);

    state_t                                  state;
    logic [BAUD_RATE_COUNTER_BITWIDTH-1:0]   baud_cnt;
    logic [TX_COUNTER_BITWIDTH-1:0]          bit_cnt;
    logic [UART_DATA_LENGTH-1:0]             shift_reg;
    logic [UART_DATA_LENGTH-1:0]             shifted;
    logic                                    tx_q;
    logic                                    ready_q;
    logic                                    done_q;
    logic                                    bit_end;
`ifdef UART_TX_PARITY_EN
    logic                                    parity_q;
`endif

    always_comb begin
        bit_end = (baud_cnt == BAUD_LAST);
        shifted = shift_reg >> 1;
    end

    assign bus.tx_o        = tx_q;
    assign bus.ready_o     = ready_q;
    assign bus.done_strb_o = done_q;

    // tx_q is loaded one edge ahead with the level of the bit that starts at
    // that edge, so the line output stays a plain register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= stIDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state)
                stIDLE: begin
                    baud_cnt <= '0;
                    done_q   <= 1'b0;
                    if (bus.data_valid_i && ready_q) begin
                        shift_reg <= bus.data_i;
                        bit_cnt   <= '0;
                        tx_q      <= 1'b0;
                        ready_q   <= 1'b0;
                        state     <= stSTARTBIT;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= ^bus.data_i;
`endif
                    end
                end

                stSTARTBIT: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_q     <= shift_reg[0];
                        state    <= stSENDING;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                stSENDING: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        shift_reg <= shifted;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state   <= stPARITY;
`else
                            tx_q    <= 1'b1;
                            done_q  <= DONE_ON_ENTRY;
                            state   <= stSTOPBIT;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_q    <= shifted[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                stPARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_q     <= 1'b1;
                        done_q   <= DONE_ON_ENTRY;
                        state    <= stSTOPBIT;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                stSTOPBIT: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        done_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        state    <= stIDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        // Raise the strobe so it is visible in the last cycle.
                        done_q   <= (baud_cnt == BAUD_PRE_LAST);
                    end
                end

                default: begin
                    state    <= stIDLE;
                    baud_cnt <= '0;
                    tx_q     <= 1'b1;
                    ready_q  <= 1'b1;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. Expected line levels come from a per-cycle
// frame description (bit index = cycle / baud) rather than from the RTL.
// With UART_TX_PARITY_EN defined a second instance at the default baud checks
// the parity frame.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (10 + PAR) * BAUD;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.UART_DATA_LENGTH(8)) bus ();

    uart_tx #(
        .UART_DATA_LENGTH(8),
        .BAUD_COUNTS_PER_BIT(BAUD),
        .BAUD_RATE_COUNTER_BITWIDTH(2),
        .TX_COUNTER_BITWIDTH(3)
    ) dut (
        .clk_i(clk),
        .reset_ni(rst_n),
        .bus(bus)
    );

`ifdef UART_TX_PARITY_EN
    uart_tx_if #(.UART_DATA_LENGTH(8)) bus2 ();

    uart_tx #(
        .UART_DATA_LENGTH(8),
        .BAUD_COUNTS_PER_BIT(521),
        .BAUD_RATE_COUNTER_BITWIDTH(10),
        .TX_COUNTER_BITWIDTH(3)
    ) dut_par (
        .clk_i(clk),
        .reset_ni(rst_n),
        .bus(bus2)
    );
`endif

    // Reference: line level at cycle cyc (0 = first cycle after accept).
    function automatic logic expect_line(input logic [7:0] d, input int baud, input int cyc);
        int b;
        b = cyc / baud;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PAR == 1 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic test_reset();
        int bad_cycles;
        bus.data_i       = '0;
        bus.data_valid_i = 1'b0;
        rst_n            = 1'b0;
        #23;
        total++;
        if (bus.tx_o !== 1'b1 || bus.ready_o !== 1'b1 || bus.done_strb_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got tx=%b ready=%b done=%b exp tx=1 ready=1 done=0",
                     bus.tx_o, bus.ready_o, bus.done_strb_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.tx_o !== 1'b1 || bus.ready_o !== 1'b1 || bus.done_strb_o !== 1'b0)
                bad_cycles++;
        end
        total++;
        if (bad_cycles !== 0) begin
            bad++;
            $display("FAIL reset_idle_hold got %0d deviating cycles exp 0", bad_cycles);
        end
    endtask

    task automatic test_frame(input logic [7:0] d, input string name);
        int done_cnt;
        int done_at;
        @(negedge clk);
        total++;
        if (bus.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before got %b exp 1", name, bus.ready_o);
        end
        bus.data_i       = d;
        bus.data_valid_i = 1'b1;
        done_cnt = 0;
        done_at  = -1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.data_valid_i = 1'b0;
                bus.data_i       = 8'($urandom);
            end
            total++;
            if (bus.tx_o !== expect_line(d, BAUD, i)) begin
                bad++;
                $display("FAIL %s line cyc=%0d got %b exp %b", name, i, bus.tx_o, expect_line(d, BAUD, i));
            end
            total++;
            if (bus.ready_o !== 1'b0) begin
                bad++;
                $display("FAIL %s ready_busy cyc=%0d got %b exp 0", name, i, bus.ready_o);
            end
            if (bus.done_strb_o === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
        end
        total++;
        if (done_cnt !== 1 || done_at !== FRAME - 1) begin
            bad++;
            $display("FAIL %s done_pulse got count=%0d at=%0d exp count=1 at=%0d",
                     name, done_cnt, done_at, FRAME - 1);
        end
        @(negedge clk);
        total++;
        if (bus.ready_o !== 1'b1 || bus.tx_o !== 1'b1 || bus.done_strb_o !== 1'b0) begin
            bad++;
            $display("FAIL %s after_frame got ready=%b tx=%b done=%b exp 1 1 0",
                     name, bus.ready_o, bus.tx_o, bus.done_strb_o);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++)
            test_frame(8'($urandom_range(0, 255)), "random");
    endtask

    task automatic test_busy_ignore();
        logic [7:0] d;
        int         line_err;
        int         idle_err;
        d = 8'hA3;
        @(negedge clk);
        bus.data_i       = d;
        bus.data_valid_i = 1'b1;
        line_err = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (bus.tx_o !== expect_line(d, BAUD, i)) line_err++;
            bus.data_valid_i = (i == 10);
            if (i == 10) bus.data_i = 8'hFF;
        end
        total++;
        if (line_err !== 0) begin
            bad++;
            $display("FAIL busy_frame got %0d wrong line cycles exp 0", line_err);
        end
        bus.data_valid_i = 1'b0;
        idle_err = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (bus.tx_o !== 1'b1 || bus.ready_o !== 1'b1) idle_err++;
        end
        total++;
        if (idle_err !== 0) begin
            bad++;
            $display("FAIL busy_no_second_frame got %0d non-idle cycles exp 0", idle_err);
        end
    endtask

    task automatic test_back_to_back();
        int   done_pos[$];
        logic exp_tx;
        logic exp_rdy;
        @(negedge clk);
        bus.data_i       = 8'h00;
        bus.data_valid_i = 1'b1;
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            @(negedge clk);
            if (i == 0) bus.data_i = 8'hFF;
            if (i == FRAME + 1) bus.data_valid_i = 1'b0;
            if (i < FRAME) exp_tx = expect_line(8'h00, BAUD, i);
            else if (i == FRAME) exp_tx = 1'b1;
            else exp_tx = expect_line(8'hFF, BAUD, i - FRAME - 1);
            exp_rdy = (i == FRAME);
            total++;
            if (bus.tx_o !== exp_tx || bus.ready_o !== exp_rdy) begin
                bad++;
                $display("FAIL b2b cyc=%0d got tx=%b ready=%b exp tx=%b ready=%b",
                         i, bus.tx_o, bus.ready_o, exp_tx, exp_rdy);
            end
            if (bus.done_strb_o === 1'b1) done_pos.push_back(i);
        end
        total++;
        if (done_pos.size() !== 2) begin
            bad++;
            $display("FAIL b2b_done_count got %0d exp 2", done_pos.size());
        end else begin
            total++;
            if (done_pos[1] - done_pos[0] !== FRAME + 1) begin
                bad++;
                $display("FAIL b2b_done_spacing got %0d exp %0d", done_pos[1] - done_pos[0], FRAME + 1);
            end
        end
        @(negedge clk);
        total++;
        if (bus.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready_end got %b exp 1", bus.ready_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int         abort_at;
        int         err;
        int         dones;
        for (int phase = 0; phase < 2; phase++) begin
            d        = (phase == 0) ? 8'h0F : 8'($urandom);
            // data bit 3 of 0x0F, then inside the start bit where the line is low
            abort_at = (phase == 0) ? 4 * BAUD + 1 : 1;
            @(negedge clk);
            bus.data_i       = d;
            bus.data_valid_i = 1'b1;
            for (int i = 0; i <= abort_at; i++) begin
                @(negedge clk);
                bus.data_valid_i = 1'b0;
                total++;
                if (bus.tx_o !== expect_line(d, BAUD, i)) begin
                    bad++;
                    $display("FAIL rst_mid_pre cyc=%0d got %b exp %b", i, bus.tx_o, expect_line(d, BAUD, i));
                end
            end
            rst_n = 1'b0;
            #1;
            total++;
            if (bus.tx_o !== 1'b1 || bus.ready_o !== 1'b1 || bus.done_strb_o !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_async phase=%0d got tx=%b ready=%b done=%b exp 1 1 0",
                         phase, bus.tx_o, bus.ready_o, bus.done_strb_o);
            end
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            err   = 0;
            dones = 0;
            for (int i = 0; i < 2 * FRAME; i++) begin
                @(negedge clk);
                if (bus.tx_o !== 1'b1 || bus.ready_o !== 1'b1) err++;
                if (bus.done_strb_o === 1'b1) dones++;
            end
            total++;
            if (err !== 0 || dones !== 0) begin
                bad++;
                $display("FAIL rst_mid_no_resume got %0d busy cycles and %0d done pulses exp 0 0", err, dones);
            end
        end
        test_frame(8'h81, "after_reset_0x81");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        int         err;
        int         done_cnt;
        int         done_at;
        int         flen;
        d    = 8'h07;
        flen = 11 * 521;
        @(negedge clk);
        bus2.data_i       = d;
        bus2.data_valid_i = 1'b1;
        err      = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int i = 0; i < flen; i++) begin
            @(negedge clk);
            bus2.data_valid_i = 1'b0;
            if (bus2.tx_o !== expect_line(d, 521, i) || bus2.ready_o !== 1'b0) err++;
            if (bus2.done_strb_o === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
            if (i == 9 * 521 + 260) begin
                total++;
                if (bus2.tx_o !== 1'b1) begin
                    bad++;
                    $display("FAIL parity_bit got %b exp 1", bus2.tx_o);
                end
            end
        end
        total++;
        if (err !== 0) begin
            bad++;
            $display("FAIL parity_frame got %0d wrong cycles exp 0", err);
        end
        total++;
        if (done_cnt !== 1 || done_at + 1 !== 5731) begin
            bad++;
            $display("FAIL parity_done got count=%0d cycle=%0d exp count=1 cycle=5731", done_cnt, done_at + 1);
        end
        @(negedge clk);
        total++;
        if (bus2.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL parity_ready_end got %b exp 1", bus2.ready_o);
        end
    endtask
`endif

    initial begin
`ifdef UART_TX_PARITY_EN
        bus2.data_i       = '0;
        bus2.data_valid_i = 1'b0;
`endif
        test_reset();
        test_frame(8'h55, "single_0x55");
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
